// File: rtl/pipe_pkg.sv
// Shared types and constants for the front-end pipeline stall/flush controller.
package pipe_pkg;

   localparam int unsigned CTRL_W_DEF = 10;
   localparam int unsigned CNT_W_DEF  = 16;
   localparam logic [31:0] NOP_INST   = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } stall_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
   } ifid_t;

   // Sequential fetch address; wraps naturally at 32 bits.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
   parameter int unsigned   W   = 16,
   parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Front-end pipeline responder: owns PC, IF/ID and ID/EX control registers,
// applies hazard-unit stall/bubble controls and ID-stage redirects, and counts events.
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned CTRL_W    = CTRL_W_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned MAX_STALL = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              hazard_sel,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              jump,
   input  logic [31:0]       jump_target,
   input  logic [31:0]       inst_mem_data,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic [31:0]       pc,
   output logic [31:0]       ifid_inst,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [1:0]        stall_state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              stall_stuck
);

   localparam int unsigned STUCK_W = $clog2(MAX_STALL + 2);

   logic [31:0]       pc_d, pc_q;
   ifid_t             ifid_d, ifid_q;
   logic [CTRL_W-1:0] idex_d, idex_q;
   stall_state_e      state_d, state_q;
   logic              stuck_d, stuck_q;

   logic               redirect_c;
   logic [31:0]        target_c;
   logic               bubble_c;
   logic [STUCK_W-1:0] consec_cnt;

   // A redirect only counts when the PC may move; jump wins over branch.
   assign redirect_c = pc_write && (jump || branch_taken);
   assign target_c   = jump ? jump_target : branch_target;
   assign bubble_c   = !hazard_sel || !ifid_q.valid;

   always_comb begin
      pc_d = pc_q;
      if (pc_write) begin
         pc_d = redirect_c ? target_c : pc_plus4(pc_q);
      end
   end

   // Flush has priority over the IF/ID hold request.
   always_comb begin
      ifid_d = ifid_q;
      if (redirect_c) begin
         ifid_d.inst  = NOP_INST;
         ifid_d.pc4   = 32'h0000_0000;
         ifid_d.valid = 1'b0;
      end else if (ifid_write) begin
         ifid_d.inst  = inst_mem_data;
         ifid_d.pc4   = pc_plus4(pc_q);
         ifid_d.valid = 1'b1;
      end
   end

   always_comb begin
      idex_d = bubble_c ? '0 : ctrl_in;
   end

   always_comb begin
      state_d = ST_RUN;
      case (state_q)
         ST_RUN, ST_FLUSH: begin
            if (!pc_write)       state_d = ST_STALL;
            else if (redirect_c) state_d = ST_FLUSH;
            else                 state_d = ST_RUN;
         end
         ST_STALL: begin
            if (redirect_c)      state_d = ST_FLUSH;
            else if (pc_write)   state_d = ST_RUN;
            else                 state_d = ST_STALL;
         end
         default:                state_d = ST_RUN;
      endcase
   end

   // Stuck flag mirrors the consecutive-stall counter after this edge exceeding MAX_STALL.
   always_comb begin
      stuck_d = !pc_write && (consec_cnt >= STUCK_W'(MAX_STALL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ifid_q  <= '0;
         idex_q  <= '0;
         state_q <= ST_RUN;
         stuck_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         idex_q  <= idex_d;
         state_q <= state_d;
         stuck_q <= stuck_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!pc_write),
      .clear (1'b0),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!hazard_sel),
      .clear (1'b0),
      .cnt   (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect_c),
      .clear (1'b0),
      .cnt   (flush_cnt)
   );

   sat_counter #(
      .W   (STUCK_W),
      .MAX (STUCK_W'(MAX_STALL + 1))
   ) u_consec_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!pc_write),
      .clear (pc_write),
      .cnt   (consec_cnt)
   );

   assign pc          = pc_q;
   assign ifid_inst   = ifid_q.inst;
   assign ifid_pc4    = ifid_q.pc4;
   assign ifid_valid  = ifid_q.valid;
   assign idex_ctrl   = idex_q;
   assign stall_state = state_q;
   assign stall_stuck = stuck_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed steps push expected post-edge state,
// a monitor pops and compares one record after every rising edge.
module tb_pipe_stall_ctrl;

   localparam int unsigned CTRL_W = 10;
   localparam int unsigned CNT_W  = 16;
   localparam logic [CTRL_W-1:0] C = 10'h3A5;
   localparam logic [1:0] RUN = 2'b00, STL = 2'b01, FLS = 2'b10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pc_write = 1'b1, ifid_write = 1'b1, hazard_sel = 1'b1;
   logic              branch_taken = 1'b0, jump = 1'b0;
   logic [31:0]       branch_target = '0, jump_target = '0;
   logic [31:0]       inst_mem_data;
   logic [CTRL_W-1:0] ctrl_in = C;
   logic [31:0]       pc, ifid_inst, ifid_pc4;
   logic              ifid_valid, stall_stuck;
   logic [CTRL_W-1:0] idex_ctrl;
   logic [1:0]        stall_state;
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;

   typedef struct {
      string             name;
      logic [31:0]       pc, inst, pc4;
      logic              valid;
      logic [CTRL_W-1:0] idex;
      logic [1:0]        st;
      logic [CNT_W-1:0]  sc, bc, fc;
      logic              stuck;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   pipe_stall_ctrl dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
      .hazard_sel(hazard_sel), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .inst_mem_data(inst_mem_data),
      .ctrl_in(ctrl_in), .pc(pc), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
      .ifid_valid(ifid_valid), .idex_ctrl(idex_ctrl), .stall_state(stall_state),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
      .stall_stuck(stall_stuck)
   );

   // Instruction memory model: the word at an address is the address itself.
   assign inst_mem_data = pc;

   always #5 clk = ~clk;

   // Legal but suspicious: PC moves on while IF/ID is held.
   always @(posedge clk) begin
      if (!rst) assert (!(pc_write && !ifid_write))
         else $warning("protocol warning: pc_write=1 with ifid_write=0");
   end

   function automatic exp_t mk(input string n, input logic [31:0] p, input logic [31:0] i,
                               input logic [31:0] p4, input logic v, input logic [CTRL_W-1:0] ix,
                               input logic [1:0] s, input logic [CNT_W-1:0] sc,
                               input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] fc,
                               input logic sk);
      exp_t e;
      e.name = n; e.pc = p; e.inst = i; e.pc4 = p4; e.valid = v; e.idex = ix;
      e.st = s; e.sc = sc; e.bc = bc; e.fc = fc; e.stuck = sk;
      return e;
   endfunction

   task automatic step(input logic r, input logic pw, input logic iw, input logic hs,
                       input logic br, input logic jp, input logic [31:0] bt,
                       input logic [31:0] jt, input exp_t e);
      @(negedge clk);
      rst = r; pc_write = pw; ifid_write = iw; hazard_sel = hs;
      branch_taken = br; jump = jp; branch_target = bt; jump_target = jt;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string n, input string f, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s.%s: got %h, expected %h", n, f, act, want);
      end
   endtask

   // Monitor: every edge produces a new register state; compare it against the next record.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "pc",          pc,                        e.pc);
            chk(e.name, "ifid_inst",   ifid_inst,                 e.inst);
            chk(e.name, "ifid_pc4",    ifid_pc4,                  e.pc4);
            chk(e.name, "ifid_valid",  32'(ifid_valid),           32'(e.valid));
            chk(e.name, "idex_ctrl",   32'(idex_ctrl),            32'(e.idex));
            chk(e.name, "stall_state", 32'(stall_state),          32'(e.st));
            chk(e.name, "stall_cnt",   32'(stall_cnt),            32'(e.sc));
            chk(e.name, "bubble_cnt",  32'(bubble_cnt),           32'(e.bc));
            chk(e.name, "flush_cnt",   32'(flush_cnt),            32'(e.fc));
            chk(e.name, "stall_stuck", 32'(stall_stuck),          32'(e.stuck));
         end
      end
   end

   initial begin
      step(1, 1, 1, 1, 0, 0, 0, 0, mk("reset",   0,      0,      0,      0, 0, RUN, 0, 0, 0, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("run1",    32'h4,  32'h0,  32'h4,  1, 0, RUN, 0, 0, 0, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("run2",    32'h8,  32'h4,  32'h8,  1, C, RUN, 0, 0, 0, 0));
      step(0, 0, 0, 0, 0, 0, 0, 0, mk("ldstall", 32'h8,  32'h4,  32'h8,  1, 0, STL, 1, 1, 0, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("resume",  32'hC,  32'h8,  32'hC,  1, C, RUN, 1, 1, 0, 0));
      step(0, 1, 1, 1, 1, 0, 32'h40, 0,
           mk("branch",  32'h40, 0,      0,      0, C, FLS, 1, 1, 1, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("postflush", 32'h44, 32'h40, 32'h44, 1, 0, RUN, 1, 1, 1, 0));
      step(0, 1, 1, 1, 1, 1, 32'h80, 32'h100,
           mk("jmpprio", 32'h100, 0,     0,      0, C, FLS, 1, 1, 2, 0));
      step(0, 0, 1, 1, 1, 1, 32'h80, 32'h200,
           mk("rdrhold", 32'h100, 32'h100, 32'h104, 1, 0, STL, 2, 1, 2, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("run3",    32'h104, 32'h100, 32'h104, 1, C, RUN, 2, 1, 2, 0));
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 0, 1, 0, 0, 0, 0,
              mk($sformatf("stall%0d", k), 32'h104, 32'h100, 32'h104, 1, C, STL,
                 CNT_W'(2 + k), 1, 2, (k >= 9)));
      end
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("unstuck", 32'h108, 32'h104, 32'h108, 1, C, RUN, 12, 1, 2, 0));
      step(0, 0, 0, 1, 0, 0, 0, 0,
           mk("satforce", 32'h108, 32'h104, 32'h108, 1, C, STL, 16'hFFFF, 1, 2, 0));
      force dut.u_stall_cnt.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.u_stall_cnt.cnt_q;
      exp_q.push_back(mk("sathold", 32'h108, 32'h104, 32'h108, 1, C, STL, 16'hFFFF, 1, 2, 0));
      step(1, 0, 0, 1, 0, 0, 0, 0, mk("rststall", 0, 0, 0, 0, 0, RUN, 0, 0, 0, 0));
      step(0, 1, 1, 1, 0, 0, 0, 0, mk("rstfetch", 32'h4, 32'h0, 32'h4, 1, 0, RUN, 0, 0, 0, 0));
      for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d records left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Front-end pipeline responder that consumes the hazard unit's stall and bubble controls (pc_write, ifid_write, hazard_sel) and the ID-stage branch/jump redirect.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control-field register, including bubble insertion.
- Tracks stall state and keeps performance counters.
- Sits between instruction memory and the ID/EX stage of the 5-stage MIPS pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 10, width of the ID/EX control bundle (RegDst, MemRead, MemWrite, ALUOp, ...)
- CNT_W, 16, width of each performance counter
- MAX_STALL, 8, consecutive stall cycles before stall_stuck asserts

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- pc_write  in  1  1 = PC may update; 0 = hold PC
- ifid_write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- hazard_sel  in  1  1 = pass ctrl_in to ID/EX; 0 = inject bubble
- branch_taken  in  1  ID-stage beq/bne resolved taken
- branch_target  in  32  branch destination
- jump  in  1  ID-stage j/jal
- jump_target  in  32  jump destination
- inst_mem_data  in  32  instruction read combinationally at pc
- ctrl_in  in  CTRL_W  decoded control bundle from ID
- pc  out  32  current fetch address
- ifid_inst  out  32  IF/ID instruction
- ifid_pc4  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- idex_ctrl  out  CTRL_W  registered ID/EX control bundle
- stall_state  out  2  FSM state encoding
- stall_cnt  out  CNT_W  cycles with pc_write=0
- bubble_cnt  out  CNT_W  bubbles injected
- flush_cnt  out  CNT_W  redirects taken
- stall_stuck  out  1  stall has persisted longer than MAX_STALL cycles

Behaviour:
- Reset: one clock, synchronous, active-high, named clk and rst as throughout the codebase; all state updates on the rising edge of clk.
- Values after any rst cycle:
  - pc=RESET_PC
  - ifid_inst=0, ifid_pc4=0, ifid_valid=0
  - idex_ctrl=0
  - all counters=0
  - stall_state=RUN
  - stall_stuck=0
- rst mid-stall or mid-flush discards everything; the first fetch after rst deasserts is at RESET_PC.
- Redirect is honoured only when pc_write=1, because an ID hazard means the branch operands are not valid yet. Redirect target priority: jump over branch_taken.
- PC update, in priority order:
  - pc_write=0: hold.
  - redirect: load the target (jump_target or branch_target).
  - otherwise: pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- IF/ID update, in priority order:
  - Redirect with pc_write=1: flush to inst=0 (nop), pc4=0, valid=0. Flush overrides ifid_write.
  - ifid_write=0: hold all fields.
  - otherwise: inst=inst_mem_data, pc4=pc+4, valid=1.
- ID/EX control:
  - Bubble when hazard_sel=0 or ifid_valid=0: idex_ctrl<=0.
  - Otherwise idex_ctrl<=ctrl_in.
  - Latency: one cycle.
- FSM, one transition per clock:
  - RUN (2'b00): pc_write=0 -> STALL; redirect -> FLUSH; else stay in RUN.
  - STALL (2'b01): pc_write=1 and redirect -> FLUSH; pc_write=1 and no redirect -> RUN; else stay in STALL.
  - FLUSH (2'b10): lasts 1 cycle. pc_write=0 -> STALL; redirect -> FLUSH; else -> RUN.
  - 2'b11 is unreachable; recover to RUN.
- Counters:
  - stall_cnt +1 per cycle with pc_write=0.
  - bubble_cnt +1 per cycle in which idex_ctrl loads a bubble because hazard_sel=0.
  - flush_cnt +1 per honoured redirect.
  - All counters saturate at all-ones; no wrap.
- stall_stuck:
  - Internal consecutive-stall counter: clears when pc_write=1, saturates at MAX_STALL+1.
  - stall_stuck is registered and high while that counter > MAX_STALL.
  - It drops on the cycle after pc_write returns to 1.
- Simultaneous pc_write=0 and ifid_write=1 is legal: IF/ID reloads the same pc instruction.
- Simultaneous pc_write=1 and ifid_write=0: PC advances and IF/ID holds. This is legal but flagged by a bench assertion as a protocol warning.

Decomposition:
- Shared package pipe_pkg holds:
  - stall_state encodings RUN/STALL/FLUSH
  - NOP_INST=32'h0000_0000
  - CTRL_W default
  - counter width
- One sub-module: sat_counter (CNT_W, inc, clear, saturates). It is instantiated for the three performance counters and for the consecutive-stall counter.

Test Plan:
- Reset then 4 free-run cycles, inst_mem_data=pc -> pc 0,4,8,12,16; ifid_pc4 tracks pc+4; ifid_valid=1 from cycle 2; state RUN.
- Load-use stall: pc_write=0, ifid_write=0, hazard_sel=0 for 1 cycle at pc=8 -> pc holds 8; IF/ID holds; idex_ctrl=0; stall_cnt=1, bubble_cnt=1; state STALL->RUN.
- Branch taken, branch_target=32'h40 at pc=12 with pc_write=1 -> next pc=32'h40; ifid_valid=0, ifid_inst=0; flush_cnt=1; state FLUSH; following idex_ctrl=0.
- jump=1 and branch_taken=1 together, jump_target=32'h100, branch_target=32'h80 -> pc=32'h100. The same stimulus with pc_write=0 -> pc holds and flush_cnt unchanged.
- pc_write=0 held 10 cycles, MAX_STALL=8 -> stall_stuck rises after the 9th consecutive stall cycle; clears the cycle after pc_write=1; stall_cnt=10.
- rst asserted during STALL, and counters preset near saturation (force stall_cnt=16'hFFFF, then stall) -> counter stays 16'hFFFF; rst returns all outputs to reset values, pc=RESET_PC.
